// File: rtl/arb_pkg.sv
// Shared types and default widths for the IF/DM memory port arbiter.
// Imported by the arbiter top and the port steering mux.
package arb_pkg;

   localparam int unsigned ADDR_W_DEF     = 64;
   localparam int unsigned DATA_W_DEF     = 64;
   localparam int unsigned MAX_CONSEC_DEF = 4;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SERVE_IF = 2'd1,
      SERVE_DM = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } owner_e;

   // Owner select is a pure function of the registered state.
   function automatic owner_e owner_of(input arb_state_e state);
      return (state == SERVE_DM) ? OWN_DM : OWN_IF;
   endfunction

endpackage : arb_pkg

// File: rtl/mem_port_mux.sv
// Bit-sliced 2:1 steering of address, write data and write strobe onto the
// shared memory port. Every output is forced to zero while no access is active.
module mem_port_mux
   import arb_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic              en,
   input  owner_e            sel,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   input  logic              dm_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we
);

   logic sel_if;
   logic sel_dm;

   assign sel_if = en & (sel == OWN_IF);
   assign sel_dm = en & (sel == OWN_DM);

   for (genvar i = 0; i < ADDR_W; i++) begin : g_addr
      assign mem_addr[i] = (sel_if & if_addr[i]) | (sel_dm & dm_addr[i]);
   end

   // IF never writes, so only the DM leg contributes to write data.
   for (genvar i = 0; i < DATA_W; i++) begin : g_wdata
      assign mem_wdata[i] = sel_dm & dm_wdata[i];
   end

   assign mem_we = sel_dm & dm_we;

endmodule : mem_port_mux

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IF (requester 0) and DM (requester 1): DM has
// priority, a consecutive-grant counter bounds IF starvation, rdata is captured per requester.
module mem_port_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned ADDR_W     = ADDR_W_DEF,
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned MAX_CONSEC = MAX_CONSEC_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_done,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_done,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              mem_valid,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              stall_if,
   output logic              stall_dm
);

   localparam int unsigned      CNT_W   = $clog2(MAX_CONSEC + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CONSEC);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   arb_state_e        state_q,      state_d;
   logic [CNT_W-1:0]  consec_cnt_q, consec_cnt_d;
   logic              if_done_q,    if_done_d;
   logic              dm_done_q,    dm_done_d;
   logic [DATA_W-1:0] if_rdata_q,   if_rdata_d;
   logic [DATA_W-1:0] dm_rdata_q,   dm_rdata_d;

   logic              if_starved;

   // IF has waited through MAX_CONSEC DM grants and must win the next tie.
   assign if_starved = if_req && (consec_cnt_q == CNT_MAX);

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and no latch is inferred.
      state_d      = state_q;
      consec_cnt_d = consec_cnt_q;
      if_done_d    = 1'b0;
      dm_done_d    = 1'b0;
      if_rdata_d   = if_rdata_q;
      dm_rdata_d   = dm_rdata_q;

      unique case (state_q)
         IDLE: begin
            if (dm_req && !if_starved) begin
               state_d = SERVE_DM;
               if (!if_req) begin
                  consec_cnt_d = '0;
               end else if (consec_cnt_q != CNT_MAX) begin
                  consec_cnt_d = consec_cnt_q + CNT_ONE;
               end
            end else if (if_req) begin
               state_d      = SERVE_IF;
               consec_cnt_d = '0;
            end
         end

         SERVE_IF: begin
            if (mem_ready) begin
               if_rdata_d = mem_rdata;
               if_done_d  = 1'b1;
               state_d    = IDLE;
            end
         end

         // A DM write captures mem_rdata as well; the value is simply unused.
         SERVE_DM: begin
            if (mem_ready) begin
               dm_rdata_d = mem_rdata;
               dm_done_d  = 1'b1;
               state_d    = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         consec_cnt_q <= '0;
         if_done_q    <= 1'b0;
         dm_done_q    <= 1'b0;
         // NOTE: the rdata holding registers are reset too, so both outputs read zero until their first capture.
         if_rdata_q   <= '0;
         dm_rdata_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge value of its neighbours.
         state_q      <= state_d;
         consec_cnt_q <= consec_cnt_d;
         if_done_q    <= if_done_d;
         dm_done_q    <= dm_done_d;
         if_rdata_q   <= if_rdata_d;
         dm_rdata_q   <= dm_rdata_d;
      end
   end

   // Decoded straight from the state flop so an async reset drops it at once.
   assign mem_valid = (state_q != IDLE);

   mem_port_mux #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_mux (
      .en        (mem_valid),
      .sel       (owner_of(state_q)),
      .if_addr   (if_addr),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .dm_we     (dm_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we)
   );

   assign if_done  = if_done_q;
   assign dm_done  = dm_done_q;
   assign if_rdata = if_rdata_q;
   assign dm_rdata = dm_rdata_q;
   assign stall_if = if_req & ~if_done_q;
   assign stall_dm = dm_req & ~dm_done_q;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus a randomized run against a transaction-level model
// of the IF/DM memory port arbiter.
module tb_mem_port_arbiter;

   localparam int ADDR_W     = 64;
   localparam int DATA_W     = 64;
   localparam int MAX_CONSEC = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              if_req, dm_req, dm_we, mem_ready;
   logic [ADDR_W-1:0] if_addr, dm_addr;
   logic [DATA_W-1:0] dm_wdata, mem_rdata;
   logic              if_done, dm_done, mem_valid, mem_we, stall_if, stall_dm;
   logic [DATA_W-1:0] if_rdata, dm_rdata, mem_wdata;
   logic [ADDR_W-1:0] mem_addr;

   int checks = 0;
   int errors = 0;
   logic [DATA_W-1:0] exp_if_rdata, exp_dm_rdata;

   mem_port_arbiter #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .MAX_CONSEC (MAX_CONSEC)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_done   (if_done),
      .if_rdata  (if_rdata),
      .dm_req    (dm_req),
      .dm_we     (dm_we),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .dm_done   (dm_done),
      .dm_rdata  (dm_rdata),
      .mem_valid (mem_valid),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .stall_if  (stall_if),
      .stall_dm  (stall_dm)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if_req    = 1'($urandom_range(0, 1));
         dm_req    = 1'($urandom_range(0, 1));
         dm_we     = 1'($urandom_range(0, 1));
         mem_ready = 1'($urandom_range(0, 1));
         if_addr   = rnd64();
         dm_addr   = rnd64();
         dm_wdata  = rnd64();
         mem_rdata = rnd64();
         @(negedge clk);
         checks++;
         if ({mem_valid, mem_we, if_done, dm_done} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctl: got valid/we/if_done/dm_done=%b expected 0000",
                     {mem_valid, mem_we, if_done, dm_done});
         end
         checks++;
         if (mem_addr !== '0 || mem_wdata !== '0 || if_rdata !== '0 || dm_rdata !== '0) begin
            errors++;
            $display("FAIL reset_data: got addr=%h wdata=%h if_rdata=%h dm_rdata=%h expected all 0",
                     mem_addr, mem_wdata, if_rdata, dm_rdata);
         end
         checks++;
         if (stall_if !== if_req || stall_dm !== dm_req) begin
            errors++;
            $display("FAIL reset_stall: got %b%b expected %b%b", stall_if, stall_dm, if_req, dm_req);
         end
      end
      if_req = 1'b0; dm_req = 1'b0; mem_ready = 1'b0; dm_we = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_valid: got %b expected 0", mem_valid);
         end
      end
      exp_if_rdata = '0;
      exp_dm_rdata = '0;
   endtask

   task automatic test_single_if();
      @(negedge clk);
      if_addr = 64'h100;
      if_req  = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (mem_valid !== 1'b1 || mem_addr !== 64'h100 || mem_we !== 1'b0 || if_done !== 1'b0 || stall_if !== 1'b1) begin
            errors++;
            $display("FAIL single_if_serve[%0d]: got valid=%b addr=%h we=%b done=%b stall=%b expected 1 100 0 0 1",
                     i, mem_valid, mem_addr, mem_we, if_done, stall_if);
         end
         if (i == 3) begin
            mem_ready = 1'b1;
            mem_rdata = 64'hDEAD;
         end
         @(negedge clk);
      end
      checks++;
      if (if_done !== 1'b1 || if_rdata !== 64'hDEAD || mem_valid !== 1'b0 || stall_if !== 1'b0 || dm_done !== 1'b0) begin
         errors++;
         $display("FAIL single_if_done: got done=%b rdata=%h valid=%b stall=%b dm_done=%b expected 1 dead 0 0 0",
                  if_done, if_rdata, mem_valid, stall_if, dm_done);
      end
      if_req    = 1'b0;
      mem_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (if_done !== 1'b0 || stall_if !== 1'b0 || if_rdata !== 64'hDEAD) begin
         errors++;
         $display("FAIL single_if_after: got done=%b stall=%b rdata=%h expected 0 0 dead", if_done, stall_if, if_rdata);
      end
      exp_if_rdata = 64'hDEAD;
   endtask

   task automatic test_simultaneous();
      @(negedge clk);
      if_addr  = 64'h300;
      dm_addr  = 64'h200;
      dm_wdata = 64'h55;
      dm_we    = 1'b1;
      if_req   = 1'b1;
      dm_req   = 1'b1;
      @(negedge clk);
      checks++;
      if (mem_valid !== 1'b1 || mem_addr !== 64'h200 || mem_we !== 1'b1 || mem_wdata !== 64'h55) begin
         errors++;
         $display("FAIL simul_dm_first: got valid=%b addr=%h we=%b wdata=%h expected 1 200 1 55",
                  mem_valid, mem_addr, mem_we, mem_wdata);
      end
      mem_ready = 1'b1;
      mem_rdata = 64'h1234;
      @(negedge clk);
      checks++;
      if (dm_done !== 1'b1 || if_done !== 1'b0 || dm_rdata !== 64'h1234 || stall_dm !== 1'b0 || stall_if !== 1'b1) begin
         errors++;
         $display("FAIL simul_dm_done: got dm_done=%b if_done=%b rdata=%h stall_dm=%b stall_if=%b expected 1 0 1234 0 1",
                  dm_done, if_done, dm_rdata, stall_dm, stall_if);
      end
      dm_req    = 1'b0;
      mem_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_valid !== 1'b1 || mem_addr !== 64'h300 || mem_we !== 1'b0 || mem_wdata !== '0) begin
         errors++;
         $display("FAIL simul_if_second: got valid=%b addr=%h we=%b wdata=%h expected 1 300 0 0",
                  mem_valid, mem_addr, mem_we, mem_wdata);
      end
      mem_ready = 1'b1;
      mem_rdata = 64'h77;
      @(negedge clk);
      checks++;
      if (if_done !== 1'b1 || dm_done !== 1'b0 || if_rdata !== 64'h77) begin
         errors++;
         $display("FAIL simul_if_done: got if_done=%b dm_done=%b rdata=%h expected 1 0 77", if_done, dm_done, if_rdata);
      end
      if_req    = 1'b0;
      mem_ready = 1'b0;
      dm_we     = 1'b0;
      @(negedge clk);
      exp_if_rdata = 64'h77;
      exp_dm_rdata = 64'h1234;
   endtask

   // Both requesters held high with a zero-latency memory: grants go D,D,D,D,I repeating.
   task automatic test_starvation();
      int grants = 0;
      logic [ADDR_W-1:0] exp_addr;
      if_addr   = 64'h1F0;
      dm_addr   = 64'hD0;
      dm_we     = 1'b0;
      if_req    = 1'b1;
      dm_req    = 1'b1;
      mem_ready = 1'b1;
      for (int cyc = 0; cyc < 60 && grants < 10; cyc++) begin
         @(negedge clk);
         checks++;
         if (if_done === 1'b1 && dm_done === 1'b1) begin
            errors++;
            $display("FAIL starve_dual_done: got both done at cycle %0d expected at most one", cyc);
         end
         if (mem_valid === 1'b1) begin
            exp_addr = ((grants % (MAX_CONSEC + 1)) == MAX_CONSEC) ? 64'h1F0 : 64'hD0;
            checks++;
            if (mem_addr !== exp_addr) begin
               errors++;
               $display("FAIL starve_grant[%0d]: got addr=%h expected %h", grants, mem_addr, exp_addr);
            end
            mem_rdata = rnd64();
            if (exp_addr == 64'h1F0) exp_if_rdata = mem_rdata;
            else                     exp_dm_rdata = mem_rdata;
            grants++;
            if (grants == 10) begin
               if_req = 1'b0;
               dm_req = 1'b0;
            end
         end
      end
      checks++;
      if (grants != 10) begin
         errors++;
         $display("FAIL starve_timeout: got %0d grants expected 10", grants);
      end
      @(negedge clk);
      mem_ready = 1'b0;
      checks++;
      if (if_done !== 1'b1 || dm_done !== 1'b0 || if_rdata !== exp_if_rdata) begin
         errors++;
         $display("FAIL starve_last_if: got if_done=%b dm_done=%b rdata=%h expected 1 0 %h",
                  if_done, dm_done, if_rdata, exp_if_rdata);
      end
      @(negedge clk);
   endtask

   task automatic test_random();
      bit                m_busy = 1'b0;
      bit                m_dm   = 1'b0;
      int                m_cnt  = 0;
      logic [ADDR_W-1:0] m_addr = '0;
      logic              m_we   = 1'b0;
      logic [DATA_W-1:0] m_wdata = '0;
      logic              p_if = 1'b0, p_dm = 1'b0, p_ready = 1'b0;
      logic [DATA_W-1:0] p_rdata = '0;
      logic              e_if_done, e_dm_done;
      bit                drain;
      for (int cyc = 0; cyc < 2500; cyc++) begin
         drain = (cyc >= 2400);
         @(negedge clk);
         e_if_done = 1'b0;
         e_dm_done = 1'b0;
         if (m_busy) begin
            if (p_ready) begin
               if (m_dm) begin e_dm_done = 1'b1; exp_dm_rdata = p_rdata; end
               else      begin e_if_done = 1'b1; exp_if_rdata = p_rdata; end
               m_busy = 1'b0;
            end
         end else if (p_if || p_dm) begin
            m_dm = p_dm && !(p_if && m_cnt == MAX_CONSEC);
            if (m_dm && p_if) m_cnt = (m_cnt < MAX_CONSEC) ? m_cnt + 1 : MAX_CONSEC;
            else              m_cnt = 0;
            m_busy  = 1'b1;
            m_addr  = m_dm ? dm_addr : if_addr;
            m_we    = m_dm & dm_we;
            m_wdata = m_dm ? dm_wdata : '0;
         end
         checks++;
         if (mem_valid !== m_busy || mem_addr !== (m_busy ? m_addr : '0) ||
             mem_we !== (m_busy & m_we) || mem_wdata !== (m_busy ? m_wdata : '0)) begin
            errors++;
            $display("FAIL rand_port[%0d]: got valid=%b addr=%h we=%b wdata=%h expected %b %h %b %h", cyc,
                     mem_valid, mem_addr, mem_we, mem_wdata, m_busy, m_busy ? m_addr : '0, m_busy & m_we,
                     m_busy ? m_wdata : '0);
         end
         checks++;
         if (if_done !== e_if_done || dm_done !== e_dm_done || if_rdata !== exp_if_rdata || dm_rdata !== exp_dm_rdata) begin
            errors++;
            $display("FAIL rand_done[%0d]: got done=%b%b if_rdata=%h dm_rdata=%h expected %b%b %h %h", cyc,
                     if_done, dm_done, if_rdata, dm_rdata, e_if_done, e_dm_done, exp_if_rdata, exp_dm_rdata);
         end
         checks++;
         if (stall_if !== (if_req & ~e_if_done) || stall_dm !== (dm_req & ~e_dm_done)) begin
            errors++;
            $display("FAIL rand_stall[%0d]: got %b%b expected %b%b", cyc, stall_if, stall_dm,
                     if_req & ~e_if_done, dm_req & ~e_dm_done);
         end
         if (drain) begin
            if_req = 1'b0;
            dm_req = 1'b0;
         end else begin
            if (!if_req) begin
               if (!(m_busy && !m_dm) && $urandom_range(0, 2) == 0) begin
                  if_req  = 1'b1;
                  if_addr = rnd64();
               end
            end else if ((e_if_done && $urandom_range(0, 1) == 0) || $urandom_range(0, 15) == 0) begin
               if_req = 1'b0;
            end
            if (!dm_req) begin
               if (!(m_busy && m_dm) && $urandom_range(0, 2) == 0) begin
                  dm_req   = 1'b1;
                  dm_addr  = rnd64();
                  dm_wdata = rnd64();
                  dm_we    = 1'($urandom_range(0, 1));
               end
            end else if ((e_dm_done && $urandom_range(0, 1) == 0) || $urandom_range(0, 15) == 0) begin
               dm_req = 1'b0;
            end
         end
         mem_ready = drain ? 1'b1 : 1'($urandom_range(0, 1));
         mem_rdata = rnd64();
         p_if      = if_req;
         p_dm      = dm_req;
         p_ready   = mem_ready;
         p_rdata   = mem_rdata;
      end
      mem_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_ready_idle();
      if_req    = 1'b0;
      dm_req    = 1'b0;
      mem_ready = 1'b1;
      mem_rdata = 64'hBEEF;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (if_done !== 1'b0 || dm_done !== 1'b0 || mem_valid !== 1'b0 ||
             if_rdata !== exp_if_rdata || dm_rdata !== exp_dm_rdata) begin
            errors++;
            $display("FAIL ready_idle[%0d]: got done=%b%b valid=%b if_rdata=%h dm_rdata=%h expected 00 0 %h %h", i,
                     if_done, dm_done, mem_valid, if_rdata, dm_rdata, exp_if_rdata, exp_dm_rdata);
         end
      end
      mem_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      if_addr = 64'h40;
      if_req  = 1'b1;
      @(negedge clk);
      checks++;
      if (mem_valid !== 1'b1 || mem_addr !== 64'h40) begin
         errors++;
         $display("FAIL rstmid_serving: got valid=%b addr=%h expected 1 40", mem_valid, mem_addr);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (mem_valid !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_async_drop: got valid=%b expected 0", mem_valid);
      end
      if_req    = 1'b0;
      mem_ready = 1'b1;
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (if_done !== 1'b0 || mem_valid !== 1'b0 || if_rdata !== '0) begin
            errors++;
            $display("FAIL rstmid_no_done[%0d]: got done=%b valid=%b rdata=%h expected 0 0 0", i,
                     if_done, mem_valid, if_rdata);
         end
      end
      mem_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_if();
      test_simultaneous();
      test_starvation();
      test_random();
      test_ready_idle();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_mem_port_arbiter
